// File: rtl/stream_mux_arb.sv
// ----------------------------------------------------------------------------
// stream_mux_arb
//
// N-channel valid/ready stream multiplexer with a registered output stage.
// A channel is chosen while idle, either by the explicit `sel` input or by a
// round-robin arbiter. Its grant is then held for the whole packet, up to and
// including the beat flagged with `last`.
//
// Optional feature macro: STREAM_MUX_ARB_RR_EN
//   defined   -> round-robin arbiter and its pointer register are built;
//                rr_mode=1 selects round-robin, rr_mode=0 selects `sel`.
//   undefined -> rr_mode is ignored and the explicit `sel` is always used.
//
// Parameters
//   NUM_CH  number of input channels (>= 2)
//   DATA_W  payload width per channel
//   SEL_W   channel-id width, derived from NUM_CH (do not override)
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_data    channel i payload at [i*DATA_W +: DATA_W]
//   in_valid   per-channel valid
//   in_last    per-channel end-of-packet flag
//   in_ready   per-channel ready, one-hot or zero
//   sel        explicit channel select, sampled only while idle
//   rr_mode    0 = explicit select, 1 = round-robin, sampled only while idle
//   out_data   registered payload
//   out_valid  registered valid
//   out_last   registered end-of-packet flag
//   out_ch     source channel of the beat on out_*
//   out_ready  downstream ready
// ----------------------------------------------------------------------------
module stream_mux_arb #(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 4,
  parameter int SEL_W  = $clog2(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  input  logic [NUM_CH-1:0]        in_valid,
  input  logic [NUM_CH-1:0]        in_last,
  output logic [NUM_CH-1:0]        in_ready,
  input  logic [SEL_W-1:0]         sel,
  input  logic                     rr_mode,
  output logic [DATA_W-1:0]        out_data,
  output logic                     out_valid,
  output logic                     out_last,
  output logic [SEL_W-1:0]         out_ch,
  input  logic                     out_ready
);

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_LOCKED = 1'b1
  } state_e;

  // Channel count at select width + 1 so an out-of-range `sel` compares
  // correctly even when NUM_CH is a power of two.
  localparam logic [SEL_W:0] NUM_CH_L = (SEL_W+1)'(NUM_CH);

  state_e              state_q, state_d;
  logic [SEL_W-1:0]    grant_q, grant_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic                out_valid_q, out_valid_d;
  logic                out_last_q, out_last_d;
  logic [SEL_W-1:0]    out_ch_q, out_ch_d;

  logic                use_rr;
  logic [SEL_W-1:0]    cand;
  logic                cand_vld;
  logic                cand_valid;
  logic                cand_last;
  logic [DATA_W-1:0]   cand_data;
  logic                slot_free;
  logic                xfer;

`ifdef STREAM_MUX_ARB_RR_EN
  // Last channel granted a packet end; the search starts just after it.
  logic [SEL_W-1:0]    ptr_q, ptr_d;
  logic [SEL_W-1:0]    rr_cand;
  logic                rr_found;

  assign use_rr = rr_mode;

  // Round-robin search: first valid channel at ptr+1, ptr+2, ... modulo NUM_CH.
  always_comb begin : rr_search
    int idx;
    rr_cand  = '0;
    rr_found = 1'b0;
    idx      = 0;
    for (int i = 1; i <= NUM_CH; i++) begin
      idx = int'(ptr_q) + i;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      if (!rr_found && in_valid[idx]) begin
        rr_found = 1'b1;
        rr_cand  = SEL_W'(idx);
      end
    end
  end
`else
  logic unused_rr_mode;

  assign use_rr         = 1'b0;
  assign unused_rr_mode = rr_mode;
`endif

  // Candidate channel: the locked grant mid-packet, else the idle-time choice.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can
    // leave it unassigned and infer a latch.
    cand     = '0;
    cand_vld = 1'b0;
    if (state_q == S_LOCKED) begin
      cand     = grant_q;
      cand_vld = 1'b1;
    end else if (use_rr) begin
`ifdef STREAM_MUX_ARB_RR_EN
      cand     = rr_cand;
      cand_vld = rr_found;
`endif
    end else begin
      cand     = sel;
      cand_vld = ({1'b0, sel} < NUM_CH_L);
    end
  end

  // Pick the candidate's beat with a compare per channel rather than a
  // variable index, so an out-of-range id can never read past the vectors.
  always_comb begin
    cand_valid = 1'b0;
    cand_last  = 1'b0;
    cand_data  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (cand_vld && (cand == SEL_W'(i))) begin
        cand_valid = in_valid[i];
        cand_last  = in_last[i];
        cand_data  = in_data[i*DATA_W +: DATA_W];
      end
    end
  end

  assign slot_free = !out_valid_q || out_ready;
  assign xfer      = cand_valid && slot_free;

  // rst_n gates ready directly so it drops the moment reset asserts, even
  // though the idle candidate could otherwise still be offered a slot.
  always_comb begin
    in_ready = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      in_ready[i] = rst_n && cand_vld && slot_free && (cand == SEL_W'(i));
    end
  end

  // Next-state: packet lock FSM, output stage and arbiter pointer.
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_ch_d    = out_ch_q;
`ifdef STREAM_MUX_ARB_RR_EN
    ptr_d       = ptr_q;
`endif
    if (xfer) begin
      // A drain and a load in the same cycle keep valid high with the new beat.
      out_data_d  = cand_data;
      out_last_d  = cand_last;
      out_ch_d    = cand;
      out_valid_d = 1'b1;
      if (cand_last) begin
        state_d = S_IDLE;
`ifdef STREAM_MUX_ARB_RR_EN
        ptr_d   = cand;
`endif
      end else begin
        state_d = S_LOCKED;
        grant_d = cand;
      end
    end else if (out_ready) begin
      // Payload fields hold; only the valid flag drops.
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      grant_q     <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_ch_q    <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples the pre-edge value regardless of statement order.
      state_q     <= state_d;
      grant_q     <= grant_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_ch_q    <= out_ch_d;
    end
  end

`ifdef STREAM_MUX_ARB_RR_EN
  // Reset to the last channel so the first search begins at channel 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= SEL_W'(NUM_CH - 1);
    end else begin
      ptr_q <= ptr_d;
    end
  end
`endif

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign out_ch    = out_ch_q;

endmodule

// File: tb/tb_stream_mux_arb.sv
// ----------------------------------------------------------------------------
// tb_stream_mux_arb
//
// Directed bench for stream_mux_arb (NUM_CH=4, DATA_W=4) with a second
// NUM_CH=3 instance for the out-of-range select case. A vector table covers
// the explicit-select packet, select change mid-packet, backpressure and
// channel switching; hand-written sequences cover mid-packet reset and, when
// STREAM_MUX_ARB_RR_EN is defined, round-robin rotation and packet lock.
// ----------------------------------------------------------------------------
module tb_stream_mux_arb;

  localparam int NUM_CH = 4;
  localparam int DATA_W = 4;
  localparam int SEL_W  = 2;

  logic                     clk;
  logic                     rst_n;
  logic [NUM_CH*DATA_W-1:0] in_data;
  logic [NUM_CH-1:0]        in_valid;
  logic [NUM_CH-1:0]        in_last;
  logic [NUM_CH-1:0]        in_ready;
  logic [SEL_W-1:0]         sel;
  logic                     rr_mode;
  logic [DATA_W-1:0]        out_data;
  logic                     out_valid;
  logic                     out_last;
  logic [SEL_W-1:0]         out_ch;
  logic                     out_ready;

  // Three-channel instance.
  logic [3*DATA_W-1:0]      in_data3;
  logic [2:0]               in_valid3;
  logic [2:0]               in_last3;
  logic [2:0]               in_ready3;
  logic [1:0]               sel3;
  logic [DATA_W-1:0]        out_data3;
  logic                     out_valid3;
  logic                     out_last3;
  logic [1:0]               out_ch3;
  logic                     out_ready3;

  int n_checks = 0;
  int n_errors = 0;

  stream_mux_arb #(.NUM_CH(NUM_CH), .DATA_W(DATA_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .sel       (sel),
    .rr_mode   (rr_mode),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_last  (out_last),
    .out_ch    (out_ch),
    .out_ready (out_ready)
  );

  stream_mux_arb #(.NUM_CH(3), .DATA_W(DATA_W)) dut3 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data3),
    .in_valid  (in_valid3),
    .in_last   (in_last3),
    .in_ready  (in_ready3),
    .sel       (sel3),
    .rr_mode   (1'b0),
    .out_data  (out_data3),
    .out_valid (out_valid3),
    .out_last  (out_last3),
    .out_ch    (out_ch3),
    .out_ready (out_ready3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [SEL_W-1:0]         sel;
    logic [NUM_CH-1:0]        valid;
    logic [NUM_CH-1:0]        last;
    logic [NUM_CH*DATA_W-1:0] data;
    logic                     oready;
    logic [NUM_CH-1:0]        exp_ready;
    logic                     exp_ovalid;
    logic [DATA_W-1:0]        exp_odata;
    logic                     exp_olast;
    logic [SEL_W-1:0]         exp_och;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_pulse();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    // Rows: inputs held for one cycle; expected in_ready for this cycle and
    // out_* as registered by the previous edges.
    //           sel   valid    last     data      ordy ready    ov  od    ol  och
    vecs[0]  = '{2'd1, 4'b1010, 4'b0000, 16'hFEAD, 1'b1, 4'b0010, 1'b0, 4'h0, 1'b0, 2'd0};
    vecs[1]  = '{2'd3, 4'b1010, 4'b0000, 16'hFEBD, 1'b1, 4'b0010, 1'b1, 4'hA, 1'b0, 2'd1};
    vecs[2]  = '{2'd3, 4'b1010, 4'b0010, 16'hFECD, 1'b0, 4'b0000, 1'b1, 4'hB, 1'b0, 2'd1};
    vecs[3]  = '{2'd3, 4'b1010, 4'b0010, 16'hFECD, 1'b0, 4'b0000, 1'b1, 4'hB, 1'b0, 2'd1};
    vecs[4]  = '{2'd3, 4'b1010, 4'b0010, 16'hFECD, 1'b0, 4'b0000, 1'b1, 4'hB, 1'b0, 2'd1};
    vecs[5]  = '{2'd3, 4'b1010, 4'b0010, 16'hFECD, 1'b1, 4'b0010, 1'b1, 4'hB, 1'b0, 2'd1};
    vecs[6]  = '{2'd3, 4'b1000, 4'b1000, 16'hFECD, 1'b1, 4'b1000, 1'b1, 4'hC, 1'b1, 2'd1};
    vecs[7]  = '{2'd3, 4'b0000, 4'b0000, 16'hFECD, 1'b1, 4'b1000, 1'b1, 4'hF, 1'b1, 2'd3};
    vecs[8]  = '{2'd3, 4'b0000, 4'b0000, 16'hFECD, 1'b0, 4'b1000, 1'b0, 4'hF, 1'b1, 2'd3};
    vecs[9]  = '{2'd0, 4'b0001, 4'b0000, 16'hFECD, 1'b0, 4'b0001, 1'b0, 4'hF, 1'b1, 2'd3};
    vecs[10] = '{2'd0, 4'b0001, 4'b0001, 16'hFEC5, 1'b0, 4'b0000, 1'b1, 4'hD, 1'b0, 2'd0};
    vecs[11] = '{2'd0, 4'b0001, 4'b0001, 16'hFEC5, 1'b1, 4'b0001, 1'b1, 4'hD, 1'b0, 2'd0};
    vecs[12] = '{2'd0, 4'b0000, 4'b0000, 16'hFEC5, 1'b1, 4'b0001, 1'b1, 4'h5, 1'b1, 2'd0};
    vecs[13] = '{2'd0, 4'b0000, 4'b0000, 16'hFEC5, 1'b1, 4'b0001, 1'b0, 4'h5, 1'b1, 2'd0};

    rst_n      = 1'b0;
    sel        = 2'd2;
    rr_mode    = 1'b0;
    in_data    = '0;
    in_valid   = '0;
    in_last    = '0;
    out_ready  = 1'b0;
    in_data3   = 12'h321;
    in_valid3  = '0;
    in_last3   = 3'b111;
    sel3       = 2'd0;
    out_ready3 = 1'b1;

    // Reset state.
    #12;
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset out_data",  32'(out_data),  32'd0);
    check("reset out_ch",    32'(out_ch),    32'd0);
    check("reset out_last",  32'(out_last),  32'd0);
    check("reset in_ready",  32'(in_ready),  32'd0);
    rst_n = 1'b1;
    #1;
    check("idle sel2 in_ready", 32'(in_ready), 32'b0100);
    tick();

    // Vector table.
    for (int i = 0; i < 14; i++) begin
      sel       = vecs[i].sel;
      in_valid  = vecs[i].valid;
      in_last   = vecs[i].last;
      in_data   = vecs[i].data;
      out_ready = vecs[i].oready;
      #1;
      check($sformatf("row%0d in_ready",  i), 32'(in_ready),  32'(vecs[i].exp_ready));
      check($sformatf("row%0d out_valid", i), 32'(out_valid), 32'(vecs[i].exp_ovalid));
      check($sformatf("row%0d out_data",  i), 32'(out_data),  32'(vecs[i].exp_odata));
      check($sformatf("row%0d out_last",  i), 32'(out_last),  32'(vecs[i].exp_olast));
      check($sformatf("row%0d out_ch",    i), 32'(out_ch),    32'(vecs[i].exp_och));
      tick();
    end

    // Out-of-range select on the three-channel instance.
    sel3      = 2'd3;
    in_valid3 = 3'b111;
    #1;
    check("nch3 sel3 in_ready", 32'(in_ready3), 32'd0);
    tick();
    check("nch3 sel3 out_valid", 32'(out_valid3), 32'd0);
    sel3 = 2'd2;
    #1;
    check("nch3 sel2 in_ready", 32'(in_ready3), 32'b100);
    tick();
    check("nch3 sel2 out_data", 32'(out_data3), 32'h3);
    check("nch3 sel2 out_ch",   32'(out_ch3),   32'd2);
    in_valid3 = '0;

    // Mid-packet reset.
    reset_pulse();
    sel       = 2'd1;
    in_valid  = 4'b0010;
    in_last   = 4'b0000;
    in_data   = 16'h0070;
    out_ready = 1'b1;
    tick();
    check("locked out_valid", 32'(out_valid), 32'd1);
    sel      = 2'd3;
    in_valid = 4'b1010;
    #1;
    check("locked in_ready", 32'(in_ready), 32'b0010);
    rst_n = 1'b0;
    #1;
    check("async rst out_valid", 32'(out_valid), 32'd0);
    check("async rst in_ready",  32'(in_ready),  32'd0);
    rst_n = 1'b1;
    #1;
    check("post rst idle in_ready", 32'(in_ready), 32'b1000);
    tick();
    in_valid = '0;

`ifdef STREAM_MUX_ARB_RR_EN
    // Round-robin rotation with every channel valid and single-beat packets.
    reset_pulse();
    rr_mode   = 1'b1;
    sel       = 2'd2;
    in_valid  = 4'b1111;
    in_last   = 4'b1111;
    in_data   = 16'hBA98;
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      check($sformatf("rr rot%0d out_valid", k), 32'(out_valid), 32'd1);
      check($sformatf("rr rot%0d out_ch",    k), 32'(out_ch),    32'(k % 4));
      check($sformatf("rr rot%0d out_data",  k), 32'(out_data),  32'(8 + (k % 4)));
    end

    // Round-robin packet lock: ch0 four beats while ch2 waits.
    reset_pulse();
    in_valid = 4'b0101;
    for (int b = 0; b < 5; b++) begin
      in_last = (b == 3) ? 4'b0101 : 4'b0100;
      in_data = {4'h0, 4'h9, 4'h0, 4'(b)};
      #1;
      check($sformatf("rr lock%0d in_ready", b), 32'(in_ready), (b < 4) ? 32'b0001 : 32'b0100);
      tick();
      check($sformatf("rr lock%0d out_ch",   b), 32'(out_ch),   (b < 4) ? 32'd0 : 32'd2);
      check($sformatf("rr lock%0d out_data", b), 32'(out_data), (b < 4) ? 32'(b) : 32'h9);
    end
    in_valid = '0;
    rr_mode  = 1'b0;
`else
    // Without the arbiter, rr_mode is ignored and `sel` still decides.
    reset_pulse();
    rr_mode   = 1'b1;
    sel       = 2'd2;
    in_valid  = 4'b0011;
    in_last   = 4'b1111;
    out_ready = 1'b1;
    #1;
    check("no-rr sel2 in_ready", 32'(in_ready), 32'b0100);
    tick();
    check("no-rr sel2 out_valid", 32'(out_valid), 32'd0);
    rr_mode  = 1'b0;
    in_valid = '0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
